// File: rtl/ibex_lsu_split.sv
// Load/store unit: drives the req/gnt/rvalid data bus and splits misaligned
// word/halfword accesses into two aligned transactions with merged load data.
module ibex_lsu_split (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_en_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        ready_ex_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  // state    | meaning
  // IDLE     | no access in flight, request driven straight from lsu_en_i
  // WAIT_RV1 | first half of a split access granted, awaiting its response
  // REQ2     | requesting the second aligned word of a split access
  // WAIT_RV  | final (or only) access granted, awaiting its response
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RV1 = 2'd1;
  localparam logic [1:0] REQ2     = 2'd2;
  localparam logic [1:0] WAIT_RV  = 2'd3;

  logic [1:0]  state, state_next;
  logic [1:0]  offset;
  logic        misaligned;
  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [31:0] addr_base;
  logic [31:0] addr_second;
  logic [63:0] wdata_dup;
  logic [31:0] rdata_lo_q;
  logic [31:0] rdata_q;
  logic [31:0] first_word, second_word;
  logic [63:0] merged;
  logic [31:0] raw;
  logic [31:0] rdata_fmt;
  logic        rvalid;
  logic        final_resp;
  logic        first_err;

  // lsu_* inputs are held stable until ready_ex_o, so they are used directly
  // in every state instead of being captured.
  assign offset = adder_result_ex_i[1:0];

  always_comb begin
    size_mask = 4'b0001;
    case (lsu_type_i)
      2'b00:   size_mask = 4'b1111;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b0001;
    endcase
  end

  // Bits that spill past byte 3 form the second access's enables.
  assign be_wide    = {4'b0000, size_mask} << offset;
  assign misaligned = (be_wide[7:4] != 4'b0000);

  assign addr_base   = {adder_result_ex_i[31:2], 2'b00};
  assign addr_second = addr_base + 32'd4;

  assign wdata_dup = {lsu_wdata_i, lsu_wdata_i} << {offset, 3'b000};

  // A response arriving together with reset must not raise any pulse.
  assign rvalid = data_rvalid_i & ~rst_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (lsu_en_i && data_gnt_i) begin
          state_next = misaligned ? WAIT_RV1 : WAIT_RV;
        end
      end
      WAIT_RV1: begin
        if (rvalid) begin
          state_next = data_err_i ? IDLE : REQ2;
        end
      end
      REQ2: begin
        if (data_gnt_i) begin
          state_next = WAIT_RV;
        end
      end
      WAIT_RV: begin
        if (rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rdata_lo_q <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state <= state_next;
      if (state == WAIT_RV1 && rvalid) begin
        rdata_lo_q <= data_rdata_i;
      end
      if (lsu_rdata_valid_o) begin
        rdata_q <= rdata_fmt;
      end
    end
  end

  assign data_req_o   = ((state == IDLE) & lsu_en_i) | (state == REQ2);
  assign data_addr_o  = (state == REQ2) ? addr_second : addr_base;
  assign data_be_o    = (state == REQ2) ? be_wide[7:4] : be_wide[3:0];
  assign data_we_o    = lsu_we_i;
  assign data_wdata_o = wdata_dup[63:32];

  always_comb begin
    first_word  = data_rdata_i;
    second_word = 32'h0;
    if (misaligned) begin
      first_word  = rdata_lo_q;
      second_word = data_rdata_i;
    end
  end

  assign merged = {second_word, first_word} >> {offset, 3'b000};
  assign raw    = merged[31:0];

  always_comb begin
    rdata_fmt = raw;
    case (lsu_type_i)
      2'b00:   rdata_fmt = raw;
      2'b01:   rdata_fmt = {{16{lsu_sign_ext_i & raw[15]}}, raw[15:0]};
      default: rdata_fmt = {{24{lsu_sign_ext_i & raw[7]}}, raw[7:0]};
    endcase
  end

  assign first_err  = (state == WAIT_RV1) & rvalid & data_err_i;
  assign final_resp = ((state == WAIT_RV) & rvalid) | first_err;

  assign ready_ex_o        = ((state == IDLE) & ~lsu_en_i) | final_resp;
  assign lsu_rdata_valid_o = (state == WAIT_RV) & rvalid & ~data_err_i & ~lsu_we_i;
  assign load_err_o        = final_resp & data_err_i & ~lsu_we_i;
  assign store_err_o       = final_resp & data_err_i & lsu_we_i;
  assign lsu_rdata_o       = lsu_rdata_valid_o ? rdata_fmt : rdata_q;
  assign busy_o            = (state != IDLE);

endmodule
